router_sync: RTL and testbench
==============================

// Module: router_sync
// PURPOSE
//  Synchronizer between the router FSM, the register block and three output FIFOs.
//  - Latches the 2-bit destination address of each packet.
//  - Steers the FSM write strobe to the addressed FIFO and reports that FIFO's full flag.
//  - Drives per-FIFO valid outputs.
//  - Issues a per-FIFO soft reset when a valid FIFO is not read within a timeout.
// PARAMETERS
//  TIMEOUT  30  consecutive stalled clock cycles before soft_reset pulses (counter width 5)
// PORTS
//  clock          in   1  single clock; all state updates on rising edge
//  resetn         in   1  asynchronous active-low reset
//  detect_add     in   1  FSM: header byte present; capture din as address
//  write_enb_reg  in   1  FSM: write strobe for the current packet
//  full           in   3  full flags of FIFO2..FIFO0
//  empty          in   3  empty flags of FIFO2..FIFO0
//  read_enb       in   3  downstream read enables of FIFO2..FIFO0
//  din            in   2  destination address (header bits [1:0])
//  vld_out        out  3  FIFO i holds data
//  soft_reset     out  3  one-cycle FIFO i flush pulse (registered)
//  write_enb      out  3  one-hot write enable into the addressed FIFO
//  fifo_full      out  1  full flag of the addressed FIFO
// BEHAVIOUR
//  - Reset (resetn=0, async): addr=2'b00, all counters=0, soft_reset=3'b000.
//  - addr register: on rising edge with detect_add=1, addr<=din; otherwise holds.
//    write_enb and fifo_full use the registered addr, so they follow one cycle after capture.
//  - write_enb (combinational) = write_enb_reg ? (1<<addr) : 3'b000.
//    addr=2'b11 is invalid and gives 3'b000.
//  - fifo_full (combinational) = full[addr]; 0 when addr=2'b11.
//  - vld_out[i] (combinational) = ~empty[i].
//  - Timeout counter i, evaluated each edge:
//    - if !vld_out[i] || read_enb[i]: cnt<=0, soft_reset[i]<=0.
//    - else if cnt==TIMEOUT-1: soft_reset[i]<=1, cnt<=0.
//    - else: cnt<=cnt+1, soft_reset[i]<=0.
//    - Net effect: soft_reset rises after the 30th consecutive stalled edge and lasts exactly
//      one cycle. It repeats every 30 cycles while the stall persists.
//  - Each counter is independent; simultaneous timeouts on several FIFOs are allowed.
//  - detect_add and write_enb_reg may be high together: write_enb still uses the old addr
//    that cycle.
//  - Reset asserted mid-count clears the counter and soft_reset immediately.
// CONFIGURATION
//  ROUTER_SYNC_TIMEOUT_EN
//  - Defined: the three timeout counters are built and soft_reset behaves as above.
//  - Undefined: no counters; soft_reset is tied to 3'b000. All other outputs are unchanged.
// STRUCTURE
//  - Package router_pkg: typedef logic [1:0] addr_t; localparam NUM_FIFO=3; TIMEOUT default;
//    ADDR_INVALID=2'b11.
//  - Sub-module router_sync_timer (inputs vld, rd; output soft_reset), instantiated 3x under
//    a generate loop.
// TESTING
//  - Reset: resetn=0 mid-operation -> soft_reset=000, write_enb=000 (addr=00, write_enb_reg=0).
//  - Address steering: detect_add=1, din=01 for one edge, then write_enb_reg=1
//    -> write_enb=010, fifo_full=full[1]; din=11 -> write_enb=000, fifo_full=0.
//  - Full mux: full=3'b111, addr=00 -> fifo_full=1; full=3'b110 -> fifo_full=0.
//  - Timeout: empty=110, read_enb=000 for 35 cycles -> vld_out=001;
//    soft_reset[0]=1 for exactly one cycle after edge 30, all other cycles 0.
//  - Read rescue: same as the timeout case, but read_enb[0]=1 at cycle 20 -> counter clears,
//    no soft_reset; a fresh 30-cycle stall then pulses.
//  - Independent channels: empty=000, read_enb=010 -> soft_reset=101 pulse at cycle 30,
//    bit1 stays 0; repeat with the macro undefined -> soft_reset stays 000.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router synchronizer.
package router_pkg;

  typedef logic [1:0] addr_t;

  localparam int unsigned NUM_FIFO     = 3;
  localparam int unsigned TIMEOUT      = 30;
  localparam int unsigned CNT_W        = 5;
  localparam addr_t       ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_sync_timer.sv
// Per-FIFO stall timer: pulses soft_reset for one cycle after Timeout consecutive
// cycles in which the FIFO holds data but is not read.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int unsigned Timeout = TIMEOUT
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             soft_reset_q, soft_reset_d;

  always_comb begin
    cnt_d        = '0;
    soft_reset_d = 1'b0;
    if (vld && !rd) begin
      if (cnt_q == CNT_W'(Timeout - 1)) begin
        soft_reset_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_sync.sv
// Router synchronizer: latches packet address, steers writes, reports full/valid and
// (with ROUTER_SYNC_TIMEOUT_EN defined) issues per-FIFO soft resets on read stalls.
module router_sync
  import router_pkg::*;
(
  input  logic                clock,
  input  logic                resetn,
  input  logic                detect_add,
  input  logic                write_enb_reg,
  input  logic [NUM_FIFO-1:0] full,
  input  logic [NUM_FIFO-1:0] empty,
  input  logic [NUM_FIFO-1:0] read_enb,
  input  addr_t               din,
  output logic [NUM_FIFO-1:0] vld_out,
  output logic [NUM_FIFO-1:0] soft_reset,
  output logic [NUM_FIFO-1:0] write_enb,
  output logic                fifo_full
);

  addr_t addr_q, addr_d;

  always_comb begin
    addr_d = detect_add ? din : addr_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Steering uses the registered address, so a capture takes effect the next cycle.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    if (addr_q != ADDR_INVALID) begin
      write_enb[addr_q] = write_enb_reg;
      fifo_full         = full[addr_q];
    end
  end

  assign vld_out = ~empty;

`ifdef ROUTER_SYNC_TIMEOUT_EN
  for (genvar g = 0; g < NUM_FIFO; g++) begin : g_timer
    router_sync_timer #(
      .Timeout(TIMEOUT)
    ) u_timer (
      .clock     (clock),
      .resetn    (resetn),
      .vld       (vld_out[g]),
      .rd        (read_enb[g]),
      .soft_reset(soft_reset[g])
    );
  end
`else
  logic unused_read_enb;
  assign unused_read_enb = ^read_enb;
  assign soft_reset      = '0;
`endif

endmodule

// File: tb/tb_router_sync.sv
// Self-checking bench for router_sync: stall-length model plus directed literal checks.
module tb_router_sync;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       detect_add = 1'b0;
  logic       write_enb_reg = 1'b0;
  logic [2:0] full = 3'b000;
  logic [2:0] empty = 3'b111;
  logic [2:0] read_enb = 3'b000;
  logic [1:0] din = 2'b00;
  logic [2:0] vld_out, soft_reset, write_enb;
  logic       fifo_full;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  router_sync dut (
    .clock        (clock),
    .resetn       (resetn),
    .detect_add   (detect_add),
    .write_enb_reg(write_enb_reg),
    .full         (full),
    .empty        (empty),
    .read_enb     (read_enb),
    .din          (din),
    .vld_out      (vld_out),
    .soft_reset   (soft_reset),
    .write_enb    (write_enb),
    .fifo_full    (fifo_full)
  );

  always #5 clock = ~clock;

  // Model: current address and length of the ongoing stall run per FIFO.
  logic [1:0] m_addr;
  int         m_run[3];

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_addr <= 2'b00;
      for (int i = 0; i < 3; i++) m_run[i] <= 0;
    end else begin
      if (detect_add) m_addr <= din;
      for (int i = 0; i < 3; i++) begin
        if (!empty[i] && !read_enb[i]) m_run[i] <= m_run[i] + 1;
        else m_run[i] <= 0;
      end
    end
  end

  function automatic logic [2:0] exp_soft();
    logic [2:0] r = 3'b000;
`ifdef ROUTER_SYNC_TIMEOUT_EN
    for (int i = 0; i < 3; i++) r[i] = (m_run[i] != 0) && (m_run[i] % 30 == 0);
`endif
    return r;
  endfunction

  function automatic logic [2:0] exp_wen();
    if (!write_enb_reg || m_addr == 2'b11) return 3'b000;
    return 3'(1 << m_addr);
  endfunction

  function automatic logic exp_full();
    if (m_addr == 2'b11) return 1'b0;
    return full[m_addr];
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_vld_out", vld_out, ~empty);
      check("model_write_enb", write_enb, exp_wen());
      check("model_fifo_full", {2'b00, fifo_full}, {2'b00, exp_full()});
      check("model_soft_reset", soft_reset, exp_soft());
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Run n edges of a fixed stall pattern; optional one-edge read on FIFO0 at rescue_edge.
  task automatic run_stall(input int n, input int rescue_edge, output int pulses,
                           output int first_edge, output logic [2:0] first_val);
    pulses = 0;
    first_edge = -1;
    first_val = 3'b000;
    for (int k = 1; k <= n; k++) begin
      @(posedge clock);
      #1;
      if (k == rescue_edge - 1) read_enb[0] = 1'b1;
      if (k == rescue_edge) read_enb[0] = 1'b0;
      #2;
      if (soft_reset != 3'b000) begin
        pulses++;
        if (first_edge < 0) begin
          first_edge = k;
          first_val = soft_reset;
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int         pulses, first_edge;
  logic [2:0] first_val;
  int         exp_pulses, exp_edge;

  initial begin
    #2 resetn = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset_soft_reset", soft_reset, 3'b000);
    check("reset_write_enb", write_enb, 3'b000);
    step();
    step();
    resetn = 1'b1;
    step();

    // Address steering to FIFO1
    detect_add = 1'b1;
    din = 2'b01;
    step();
    detect_add = 1'b0;
    write_enb_reg = 1'b1;
    full = 3'b010;
    #1;
    check("steer_wen_01", write_enb, 3'b010);
    check("steer_full_01", {2'b00, fifo_full}, 3'b001);
    full = 3'b101;
    #1;
    check("steer_notfull_01", {2'b00, fifo_full}, 3'b000);
    step();

    // Invalid address
    detect_add = 1'b1;
    din = 2'b11;
    full = 3'b111;
    step();
    detect_add = 1'b0;
    #1;
    check("invalid_wen", write_enb, 3'b000);
    check("invalid_full", {2'b00, fifo_full}, 3'b000);

    // Full mux on FIFO0
    detect_add = 1'b1;
    din = 2'b00;
    step();
    detect_add = 1'b0;
    #1;
    check("mux_full_00", {2'b00, fifo_full}, 3'b001);
    check("mux_wen_00", write_enb, 3'b001);
    full = 3'b110;
    #1;
    check("mux_notfull_00", {2'b00, fifo_full}, 3'b000);

    // Capture and write in the same cycle: old address steers until the edge
    detect_add = 1'b1;
    din = 2'b10;
    #1;
    check("same_cycle_old_addr", write_enb, 3'b001);
    step();
    detect_add = 1'b0;
    #1;
    check("same_cycle_new_addr", write_enb, 3'b100);
    write_enb_reg = 1'b0;
    full = 3'b000;
    step();

`ifdef ROUTER_SYNC_TIMEOUT_EN
    exp_pulses = 1;
`else
    exp_pulses = 0;
`endif

    // Timeout on FIFO0
    empty = 3'b110;
    read_enb = 3'b000;
    #1;
    check("timeout_vld", vld_out, 3'b001);
    run_stall(35, -10, pulses, first_edge, first_val);
    exp_edge = (exp_pulses != 0) ? 30 : -1;
    check("timeout_pulses", 3'(pulses), 3'(exp_pulses));
    check("timeout_edge", 3'(first_edge / 8), 3'(exp_edge / 8));
    check("timeout_edge_lo", 3'(first_edge), 3'(exp_edge));
    empty = 3'b111;
    step();
    step();

    // Reset asserted mid-stall
    empty = 3'b110;
    repeat (10) step();
    write_enb_reg = 1'b0;
    resetn = 1'b0;
    #1;
    check("midreset_soft_reset", soft_reset, 3'b000);
    check("midreset_write_enb", write_enb, 3'b000);
    write_enb_reg = 1'b1;
    #1;
    check("midreset_addr_00", write_enb, 3'b001);
    write_enb_reg = 1'b0;
    step();
    resetn = 1'b1;
    empty = 3'b111;
    step();

    // Read rescue at edge 20, fresh stall pulses at edge 50
    empty = 3'b110;
    run_stall(55, 20, pulses, first_edge, first_val);
    exp_edge = (exp_pulses != 0) ? 50 : -1;
    check("rescue_pulses", 3'(pulses), 3'(exp_pulses));
    check("rescue_edge", 3'(first_edge / 8), 3'(exp_edge / 8));
    check("rescue_edge_lo", 3'(first_edge), 3'(exp_edge));
    empty = 3'b111;
    step();
    step();

    // Independent channels: FIFO1 is being read
    empty = 3'b000;
    read_enb = 3'b010;
    run_stall(35, -10, pulses, first_edge, first_val);
    exp_edge = (exp_pulses != 0) ? 30 : -1;
    check("indep_pulses", 3'(pulses), 3'(exp_pulses));
    check("indep_value", first_val, (exp_pulses != 0) ? 3'b101 : 3'b000);
    check("indep_edge", 3'(first_edge), 3'(exp_edge));
    empty = 3'b111;
    read_enb = 3'b000;
    step();
    step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
